// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RV32/RV64 immediate generator.
// The decode is combinational into a one-entry output register (O) backed by
// one skid entry (S). The skid lets in_ready come straight off a flop while
// still sustaining one instruction per cycle. A saturating counter tracks
// accepted illegal opcodes for debug.
module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  imm,
   output logic [2:0]       imm_fmt,
   output logic             illegal,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] illegal_cnt
);

   typedef enum logic [2:0] {
      FMT_R   = 3'd0,
      FMT_I   = 3'd1,
      FMT_S   = 3'd2,
      FMT_B   = 3'd3,
      FMT_U   = 3'd4,
      FMT_J   = 3'd5,
      FMT_ILL = 3'd7
   } fmt_e;

   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic [2:0]      fmt;
      logic            ill;
   } res_t;

   res_t              dec;
   res_t              o_q;
   res_t              s_q;
   logic              o_vld;
   logic              s_empty;
   logic              accept;
   logic signed [31:0] imm32;

   // S empty is kept as its own flop so that in_ready is a plain register output
   assign in_ready = s_empty;
   assign accept   = in_valid && s_empty;

   // Decode the immediate at 32 bits. The signed cast then widens it to XLEN,
   // so instr[31] is the sign bit for every format.
   always_comb begin
      imm32   = '0;
      dec     = '0;
      dec.fmt = FMT_ILL;
      dec.ill = 1'b1;
      case (instr[6:0])
         7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: begin
            imm32   = {{20{instr[31]}}, instr[31:20]};
            dec.fmt = FMT_I;
            dec.ill = 1'b0;
         end
         7'b0100011: begin
            imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            dec.fmt = FMT_S;
            dec.ill = 1'b0;
         end
         7'b1100011: begin
            imm32   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            dec.fmt = FMT_B;
            dec.ill = 1'b0;
         end
         7'b0110111, 7'b0010111: begin
            imm32   = {instr[31:12], 12'b0};
            dec.fmt = FMT_U;
            dec.ill = 1'b0;
         end
         7'b1101111: begin
            imm32   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            dec.fmt = FMT_J;
            dec.ill = 1'b0;
         end
         7'b0110011: begin
            dec.fmt = FMT_R;
            dec.ill = 1'b0;
         end
         default: ;
      endcase
      dec.imm = XLEN'(imm32);
   end

   // Output register plus skid entry. S only fills when O is stalled, and it
   // drains into O before anything new is accepted, so order is preserved.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_vld   <= 1'b0;
         s_empty <= 1'b1;
         o_q     <= '0;
         s_q     <= '0;
      end else if (!s_empty) begin
         if (out_ready) begin
            o_q     <= s_q;
            s_empty <= 1'b1;
         end
      end else if (accept) begin
         if (!o_vld || out_ready) begin
            o_q   <= dec;
            o_vld <= 1'b1;
         end else begin
            s_q     <= dec;
            s_empty <= 1'b0;
         end
      end else if (out_ready) begin
         o_vld <= 1'b0;
      end
   end

   // Saturating illegal-opcode counter. A clear beats a simultaneous increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illegal_cnt <= '0;
      end else if (cnt_clr) begin
         illegal_cnt <= '0;
      end else if (accept && dec.ill && (illegal_cnt != '1)) begin
         illegal_cnt <= illegal_cnt + CNT_W'(1);
      end
   end

   assign out_valid = o_vld;
   assign imm       = o_q.imm;
   assign imm_fmt   = o_q.fmt;
   assign illegal   = o_q.ill;

endmodule
